// File: rtl/ram_access_ctrl_pkg.sv
// ram_access_ctrl_pkg
// Shared types for the RAM access controller: datapath widths, the FSM state
// encoding, the latched transaction record and the registered output bundle.
package ram_access_ctrl_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAR  = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_ACK  = 3'd4
  } state_e;

  // Transaction captured in IDLE; the requester may change its inputs afterwards.
  typedef struct packed {
    logic              prog;   // 1 = programmer owns this transaction
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  // Everything driven towards the RAM/MAR and the CPU handshake, except read data.
  typedef struct packed {
    logic              mar_load;
    logic              ram_we;
    logic              ram_oe;
    logic              cpu_ack;
    logic              busy;
    logic [ADDR_W-1:0] mar_addr;
    logic [DATA_W-1:0] ram_wdata;
  } out_t;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// ram_access_ctrl_if
// CPU control-path access handshake.
//   cpu_req   : request, held high until cpu_ack
//   cpu_we    : 1 = write, 0 = read, valid with cpu_req
//   cpu_addr  : access address
//   cpu_wdata : write data
//   cpu_ack   : one-cycle completion pulse
//   cpu_rdata : read result, held until the next read completes
// master = CPU side, slave = controller side.
interface ram_access_ctrl_if;
  import ram_access_ctrl_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata
  );
endinterface

// File: rtl/ram_access_ctrl_button_debouncer.sv
// button_debouncer
// Turns the raw front-panel push-button into a clean one-cycle strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   button     : raw asynchronous bouncing input
//   strobe     : one-cycle pulse on each accepted rising edge of the button
// The synchronised level must differ from the accepted level for
// DEBOUNCE_CYCLES consecutive samples before it is accepted.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic strobe
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          strobe_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, exactly like the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      level_q  <= 1'b0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], button};
      strobe_q <= 1'b0;
      if (sync_q[1] != level_q) begin
        // Any sample equal to the accepted level clears the run below.
        if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          level_q  <= sync_q[1];
          cnt_q    <= '0;
          strobe_q <= sync_q[1];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// Sequencer and arbiter for the 16x8 RAM and its MAR. The front-panel
// programmer and the CPU never touch RAM controls directly; this block
// issues MAR load, RAM write and RAM output-enable strobes on their behalf.
//   clk, rst_n         : clock, asynchronous active-low reset
//   prog_mode          : 1 = programmer owns RAM, 0 = CPU owns RAM
//   addr_button        : raw programmer push-button
//   dip_addr, dip_data : programmer address and data switches
//   cpu                : CPU req/ack handshake (slave side)
//   ram_rdata          : RAM read data
//   mar_load, mar_addr : MAR load strobe and address
//   ram_we, ram_wdata  : RAM write strobe and data
//   ram_oe             : RAM output enable
//   busy               : high whenever the FSM is not idle
//   prog_count         : number of programmer writes, wrapping
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_mode,
  input  logic              addr_button,
  input  logic [ADDR_W-1:0] dip_addr,
  input  logic [DATA_W-1:0] dip_data,
  ram_access_ctrl_if.slave  cpu,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              mar_load,
  output logic [ADDR_W-1:0] mar_addr,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic [CNT_W-1:0]  prog_count
);

  state_e            state_q, state_d;
  txn_t              txn_q, txn_d;
  out_t              out_q, out_d;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [CNT_W-1:0]  prog_count_q;
  logic              prog_strobe;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .rst_n  (rst_n),
    .button (addr_button),
    .strobe (prog_strobe)
  );

  // State register, transaction latch, output flops and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      txn_q        <= '0;
      out_q        <= '0;
      cpu_rdata_q  <= '0;
      prog_count_q <= '0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      out_q   <= out_d;
      if (state_q == ST_RD) begin
        cpu_rdata_q <= ram_rdata;
      end
      if (state_q == ST_WR && txn_q.prog) begin
        prog_count_q <= prog_count_q + 1'b1;
      end
    end
  end

  // Next state. Requests are only looked at in IDLE, which is what keeps the
  // two owners apart and lets a mode change wait for the current transaction.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    txn_d   = txn_q;
    unique case (state_q)
      ST_IDLE: begin
        if (prog_mode && prog_strobe) begin
          txn_d   = '{prog: 1'b1, we: 1'b1, addr: dip_addr, data: dip_data};
          state_d = ST_MAR;
        end else if (!prog_mode && cpu.cpu_req) begin
          txn_d   = '{prog: 1'b0, we: cpu.cpu_we, addr: cpu.cpu_addr, data: cpu.cpu_wdata};
          state_d = ST_MAR;
        end
      end
      ST_MAR:  state_d = txn_q.we ? ST_WR : ST_RD;
      ST_WR:   state_d = txn_q.prog ? ST_IDLE : ST_ACK;
      ST_RD:   state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state and registered, so each strobe is a
  // clean flop output that lines up with the state it belongs to.
  always_comb begin
    out_d      = '0;
    out_d.busy = (state_d != ST_IDLE);
    unique case (state_d)
      ST_MAR: begin
        out_d.mar_load = 1'b1;
        out_d.mar_addr = txn_d.addr;
      end
      ST_WR: begin
        out_d.ram_we    = 1'b1;
        out_d.ram_wdata = txn_d.data;
      end
      ST_RD:   out_d.ram_oe  = 1'b1;
      ST_ACK:  out_d.cpu_ack = 1'b1;
      default: ;
    endcase
  end

  assign mar_load      = out_q.mar_load;
  assign mar_addr      = out_q.mar_addr;
  assign ram_we        = out_q.ram_we;
  assign ram_oe        = out_q.ram_oe;
  assign ram_wdata     = out_q.ram_wdata;
  assign busy          = out_q.busy;
  assign cpu.cpu_ack   = out_q.cpu_ack;
  assign cpu.cpu_rdata = cpu_rdata_q;
  assign prog_count    = prog_count_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl
// Directed bench for ram_access_ctrl with a behavioural 16x8 RAM + MAR model.
module tb_ram_access_ctrl;
  import ram_access_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              prog_mode;
  logic              addr_button;
  logic [ADDR_W-1:0] dip_addr;
  logic [DATA_W-1:0] dip_data;
  logic [DATA_W-1:0] ram_rdata;
  logic              mar_load;
  logic [ADDR_W-1:0] mar_addr;
  logic              ram_we;
  logic              ram_oe;
  logic [DATA_W-1:0] ram_wdata;
  logic              busy;
  logic [7:0]        prog_count;

  ram_access_ctrl_if cpu_bus ();

  ram_access_ctrl #(
    .DEBOUNCE_CYCLES(16),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_mode   (prog_mode),
    .addr_button (addr_button),
    .dip_addr    (dip_addr),
    .dip_data    (dip_data),
    .cpu         (cpu_bus),
    .ram_rdata   (ram_rdata),
    .mar_load    (mar_load),
    .mar_addr    (mar_addr),
    .ram_we      (ram_we),
    .ram_oe      (ram_oe),
    .ram_wdata   (ram_wdata),
    .busy        (busy),
    .prog_count  (prog_count)
  );

  always #5 clk = ~clk;

  // RAM and MAR model driven only by the controller's strobes.
  logic [DATA_W-1:0] mem [16];
  logic [ADDR_W-1:0] mar_q = '0;
  always @(posedge clk) begin
    if (mar_load) mar_q <= mar_addr;
    if (ram_we)   mem[mar_q] <= ram_wdata;
  end
  assign ram_rdata = ram_oe ? mem[mar_q] : 8'h00;

  // Strobe counters for "exactly one" / "none" checks.
  int mar_cnt = 0, we_cnt = 0, ack_cnt = 0;
  always @(posedge clk) begin
    if (mar_load)        mar_cnt <= mar_cnt + 1;
    if (ram_we)          we_cnt  <= we_cnt + 1;
    if (cpu_bus.cpu_ack) ack_cnt <= ack_cnt + 1;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous properties: strobes one-hot-or-zero, ack never longer than a cycle.
  logic ack_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("strobes_onehot0", 32'($onehot0({mar_load, ram_we, ram_oe})), 32'd1);
      check("ack_single_cycle", 32'(ack_prev & cpu_bus.cpu_ack), 32'd0);
    end
    ack_prev = cpu_bus.cpu_ack & rst_n;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic wait_mar(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (mar_load) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One programmer write: press, expect MAR then WR, release and let it settle.
  task automatic prog_write(input logic [3:0] a, input logic [7:0] d, input string tag);
    bit ok;
    dip_addr    = a;
    dip_data    = d;
    addr_button = 1'b1;
    wait_mar(40, ok);
    check({tag, "_mar_timeout"}, 32'(ok), 32'd1);
    if (ok) begin
      check({tag, "_mar_addr"}, 32'(mar_addr), 32'(a));
      @(negedge clk);
      check({tag, "_we"}, 32'(ram_we), 32'd1);
      check({tag, "_wdata"}, 32'(ram_wdata), 32'(d));
    end
    addr_button = 1'b0;
    repeat (22) @(negedge clk);
  endtask

  // One CPU access, called at a negedge with the FSM idle.
  task automatic cpu_access(input int idx, input bit we, input logic [3:0] a,
                            input logic [7:0] wd, input logic [7:0] exp_rd);
    cpu_bus.cpu_req   = 1'b1;
    cpu_bus.cpu_we    = we;
    cpu_bus.cpu_addr  = a;
    cpu_bus.cpu_wdata = wd;
    @(negedge clk);
    check($sformatf("cpu%0d_c1_mar_load", idx), 32'(mar_load), 32'd1);
    check($sformatf("cpu%0d_c1_mar_addr", idx), 32'(mar_addr), 32'(a));
    check($sformatf("cpu%0d_c1_busy", idx), 32'(busy), 32'd1);
    @(negedge clk);
    check($sformatf("cpu%0d_c2_we", idx), 32'(ram_we), 32'(we));
    check($sformatf("cpu%0d_c2_oe", idx), 32'(ram_oe), 32'(!we));
    if (we) check($sformatf("cpu%0d_c2_wdata", idx), 32'(ram_wdata), 32'(wd));
    @(negedge clk);
    check($sformatf("cpu%0d_c3_ack", idx), 32'(cpu_bus.cpu_ack), 32'd1);
    check($sformatf("cpu%0d_c3_rdata", idx), 32'(cpu_bus.cpu_rdata), 32'(exp_rd));
    cpu_bus.cpu_req = 1'b0;
    @(negedge clk);
    check($sformatf("cpu%0d_after_ack", idx), 32'(cpu_bus.cpu_ack), 32'd0);
    check($sformatf("cpu%0d_after_busy", idx), 32'(busy), 32'd0);
  endtask

  typedef struct {
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;  // value cpu_rdata must show while cpu_ack is high
  } vec_t;

  vec_t vecs [9];

  initial begin
    int m0, w0, a0;
    logic [7:0] cnt0;
    bit ok;

    // Expected rdata: reads return the RAM contents; writes leave the last
    // read result in place. Address 3 holds 0F from the programmer test.
    vecs[0] = '{1'b1, 4'hA, 8'hF0, 8'h00};
    vecs[1] = '{1'b0, 4'hA, 8'h00, 8'hF0};
    vecs[2] = '{1'b1, 4'h0, 8'h55, 8'hF0};
    vecs[3] = '{1'b1, 4'hF, 8'hAA, 8'hF0};
    vecs[4] = '{1'b0, 4'h0, 8'h00, 8'h55};
    vecs[5] = '{1'b0, 4'hF, 8'h00, 8'hAA};
    vecs[6] = '{1'b0, 4'h3, 8'h00, 8'h0F};
    vecs[7] = '{1'b1, 4'hA, 8'h3C, 8'h0F};
    vecs[8] = '{1'b0, 4'hA, 8'h00, 8'h3C};

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst_n             = 1'b0;
    prog_mode         = 1'b0;
    addr_button       = 1'b0;
    dip_addr          = '0;
    dip_data          = '0;
    cpu_bus.cpu_req   = 1'b0;
    cpu_bus.cpu_we    = 1'b0;
    cpu_bus.cpu_addr  = '0;
    cpu_bus.cpu_wdata = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_mar_load", 32'(mar_load), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_oe", 32'(ram_oe), 32'd0);
    check("rst_cpu_ack", 32'(cpu_bus.cpu_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_prog_count", 32'(prog_count), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_bus.cpu_rdata), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Programmer write with a bouncing button: exactly one MAR + WR.
    prog_mode = 1'b1;
    dip_addr  = 4'h3;
    dip_data  = 8'h0F;
    m0 = mar_cnt;
    w0 = we_cnt;
    for (int b = 0; b < 3; b++) begin
      addr_button = 1'b1;
      repeat (3) @(negedge clk);
      addr_button = 1'b0;
      repeat (2) @(negedge clk);
    end
    addr_button = 1'b1;
    repeat (60) @(negedge clk);
    check("prog_single_mar", 32'(mar_cnt - m0), 32'd1);
    check("prog_single_we", 32'(we_cnt - w0), 32'd1);
    check("prog_mar_value", 32'(mar_q), 32'h3);
    check("prog_mem3", 32'(mem[3]), 32'h0F);
    check("prog_count_1", 32'(prog_count), 32'd1);
    addr_button = 1'b0;
    repeat (25) @(negedge clk);

    // CPU accesses from the vector table.
    prog_mode = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cpu_access(i, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
    end
    check("cpu_mem_A", 32'(mem[4'hA]), 32'h3C);

    // Contention: CPU request stalls while the programmer owns RAM.
    prog_mode         = 1'b1;
    cpu_bus.cpu_req   = 1'b1;
    cpu_bus.cpu_we    = 1'b0;
    cpu_bus.cpu_addr  = 4'hA;
    m0 = mar_cnt;
    a0 = ack_cnt;
    repeat (10) @(negedge clk);
    check("stall_no_mar", 32'(mar_cnt - m0), 32'd0);
    check("stall_no_ack", 32'(ack_cnt - a0), 32'd0);
    check("stall_not_busy", 32'(busy), 32'd0);
    prog_mode = 1'b0;
    @(negedge clk);
    check("unstall_c1_mar", 32'(mar_load), 32'd1);
    @(negedge clk);
    check("unstall_c2_oe", 32'(ram_oe), 32'd1);
    @(negedge clk);
    check("unstall_c3_ack", 32'(cpu_bus.cpu_ack), 32'd1);
    check("unstall_c3_rdata", 32'(cpu_bus.cpu_rdata), 32'h3C);
    cpu_bus.cpu_req = 1'b0;
    @(negedge clk);
    check("unstall_idle", 32'(busy), 32'd0);

    // Reset asserted in the middle of a programmer WR cycle.
    prog_mode   = 1'b1;
    dip_addr    = 4'h5;
    dip_data    = 8'h77;
    addr_button = 1'b1;
    wait_mar(40, ok);
    check("rstmid_mar_timeout", 32'(ok), 32'd1);
    @(negedge clk);
    check("rstmid_in_wr", 32'(ram_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_we_async", 32'(ram_we), 32'd0);
    check("rstmid_busy_async", 32'(busy), 32'd0);
    check("rstmid_count_async", 32'(prog_count), 32'd0);
    addr_button = 1'b0;
    w0 = we_cnt;
    a0 = ack_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("rstmid_no_we_after", 32'(we_cnt - w0), 32'd0);
    check("rstmid_no_ack_after", 32'(ack_cnt - a0), 32'd0);
    check("rstmid_mem5_untouched", 32'(mem[5]), 32'h00);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_count", 32'(prog_count), 32'd0);
    check("rstmid_rdata", 32'(cpu_bus.cpu_rdata), 32'd0);

    // 256 programmer writes wrap the counter back to 0.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      prog_write(iv[3:0], iv ^ 8'hA5, "wrap");
      if (i == 254) check("wrap_count_255", 32'(prog_count), 32'd255);
    end
    check("wrap_count_0", 32'(prog_count), 32'd0);
    check("wrap_mem_F", 32'(mem[4'hF]), 32'(8'hFF ^ 8'hA5));

    // Button strobe landing while a CPU write is in flight is dropped.
    prog_mode = 1'b0;
    m0   = mar_cnt;
    a0   = ack_cnt;
    cnt0 = prog_count;
    addr_button = 1'b1;
    repeat (17) @(negedge clk);
    cpu_bus.cpu_req   = 1'b1;
    cpu_bus.cpu_we    = 1'b1;
    cpu_bus.cpu_addr  = 4'h7;
    cpu_bus.cpu_wdata = 8'h99;
    @(negedge clk);
    check("drop_c1_mar", 32'(mar_load), 32'd1);
    prog_mode = 1'b1;
    @(negedge clk);
    check("drop_c2_we", 32'(ram_we), 32'd1);
    @(negedge clk);
    check("drop_c3_ack", 32'(cpu_bus.cpu_ack), 32'd1);
    cpu_bus.cpu_req = 1'b0;
    repeat (40) @(negedge clk);
    check("drop_single_mar", 32'(mar_cnt - m0), 32'd1);
    check("drop_single_ack", 32'(ack_cnt - a0), 32'd1);
    check("drop_count_same", 32'(prog_count), 32'(cnt0));
    check("drop_mem7", 32'(mem[7]), 32'h99);
    addr_button = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
